// File: rtl/rng_roll_ctrl.sv
// rng_roll_ctrl
//   Dice-roll sequencer for the 4-bit random datapath. Issues advance pulses
//   to the LFSR at a slowing rate, latches each sample for display, keeps a
//   short history of final results and replays it on request.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | nothing rolled since reset, display blank (0)
//   ROLL  | stepping the LFSR, interval grows after every step
//   HOLD  | roll finished, last result frozen on the display
//   SHOW  | history replay, newest first, one entry per SHOW_PERIOD
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_stop     debounced keys, acted on at their rising edge
//   i_show              debounced key, level: replay while high
//   i_rand              current LFSR value
//   o_step              one-cycle advance pulse to the LFSR
//   o_out               displayed value
//   o_state             IDLE=0, ROLL=1, HOLD=2, SHOW=3
//   o_hist_cnt          number of valid history entries
module rng_roll_ctrl #(
    parameter int INIT_PERIOD = 4,
    parameter int PERIOD_INC  = 4,
    parameter int MAX_PERIOD  = 64,
    parameter int HIST_DEPTH  = 4,
    parameter int SHOW_PERIOD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_show,
    input  logic [3:0] i_rand,
    output logic       o_step,
    output logic [3:0] o_out,
    output logic [1:0] o_state,
    output logic [2:0] o_hist_cnt
);

    localparam int CW = $clog2(MAX_PERIOD + 1);
    localparam int IW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int SW = $clog2(SHOW_PERIOD + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROLL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_SHOW = 2'd3;

    logic [1:0]    state;
    logic          start_q, stop_q;
    logic          start_rise, stop_rise;
    logic [CW-1:0] period, cnt;
    logic [CW:0]   next_period;
    logic          tick, finish;
    logic [3:0]    out_q;
    logic [3:0]    hist [HIST_DEPTH];
    logic [2:0]    hist_cnt;
    logic [IW-1:0] idx;
    logic [SW-1:0] show_cnt;
    logic          push_en;
    logic [3:0]    push_val;

    assign start_rise  = i_start & ~start_q;
    assign stop_rise   = i_stop & ~stop_q;
    assign tick        = (state == ST_ROLL) && (cnt == period - CW'(1));
    // One bit wider so the overshoot past MAX_PERIOD cannot wrap.
    assign next_period = {1'b0, period} + (CW+1)'(PERIOD_INC);
    assign finish      = next_period > (CW+1)'(MAX_PERIOD);

    // A restart swallows a coincident tick: no advance, no latch.
    assign o_step = tick & ~start_rise;

    // On a tick the freshly latched sample is the one recorded.
    assign push_en  = (state == ST_ROLL) && !start_rise && (stop_rise || (tick && finish));
    assign push_val = tick ? i_rand : out_q;

    assign o_out      = (state == ST_SHOW) ? hist[idx] : out_q;
    assign o_state    = state;
    assign o_hist_cnt = hist_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            period   <= '0;
            cnt      <= '0;
            out_q    <= '0;
            idx      <= '0;
            show_cnt <= '0;
        end else begin
            start_q <= i_start;
            stop_q  <= i_stop;
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (start_rise) begin
                        state  <= ST_ROLL;
                        period <= CW'(INIT_PERIOD);
                        cnt    <= '0;
                    end else if (i_show && hist_cnt != 3'd0) begin
                        state    <= ST_SHOW;
                        idx      <= '0;
                        show_cnt <= '0;
                    end
                end
                ST_ROLL: begin
                    if (start_rise) begin
                        period <= CW'(INIT_PERIOD);
                        cnt    <= '0;
                    end else if (tick) begin
                        out_q <= i_rand;
                        cnt   <= '0;
                        if (stop_rise || finish) begin
                            state <= ST_HOLD;
                        end else begin
                            period <= next_period[CW-1:0];
                        end
                    end else if (stop_rise) begin
                        state <= ST_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SHOW: begin
                    if (start_rise) begin
                        state  <= ST_ROLL;
                        period <= CW'(INIT_PERIOD);
                        cnt    <= '0;
                    end else if (!i_show) begin
                        state <= ST_HOLD;
                        out_q <= hist[0];
                    end else if (show_cnt == SW'(SHOW_PERIOD - 1)) begin
                        show_cnt <= '0;
                        if (3'(idx) == hist_cnt - 3'd1) begin
                            idx <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        show_cnt <= show_cnt + SW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // History shift register, newest entry at hist[0].
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) hist[i] <= '0;
            hist_cnt <= '0;
        end else if (push_en) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
            hist[0] <= push_val;
            if (hist_cnt != 3'(HIST_DEPTH)) hist_cnt <= hist_cnt + 3'd1;
        end
    end

endmodule
